// File: rtl/lw_sha_pkg.sv
// Shared SHA/HMAC definitions: key feeder state, key block size, HMAC pad bytes.
// No logic; WORD_SIZE follows the build-wide `WORD_SIZE define (32 if undefined).
// Imported by the key feeder interface and the key feeder block.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package lw_sha_pkg;

  localparam int WORD_SIZE       = `WORD_SIZE;
  localparam int KEY_BLOCK_WORDS = 16;
  localparam int KEY_IDX_W       = $clog2(KEY_BLOCK_WORDS);

  // Inner/outer pad bytes, consumed by the HMAC core when it XORs the key block.
  localparam logic [7:0] HMAC_IPAD = 8'h36;
  localparam logic [7:0] HMAC_OPAD = 8'h5c;

  typedef enum logic [1:0] {
    FEED_EMPTY  = 2'd0,
    FEED_LOADED = 2'd1,
    FEED_STREAM = 2'd2
  } feed_state_e;

endpackage

// File: rtl/lw_hmac_key_feeder_if.sv
// Key stream from the feeder to the HMAC core key port (valid/ready).
// Signals: key_o (core key_i), key_valid_o (core key_valid_i), key_ready_i (core key_ready_o).
// master = feeder side, slave = HMAC core side.
interface lw_hmac_key_feeder_if;
  import lw_sha_pkg::*;

  logic [WORD_SIZE-1:0] key_o;
  logic                 key_valid_o;
  logic                 key_ready_i;

  modport master (output key_o, output key_valid_o, input key_ready_i);
  modport slave  (input key_o, input key_valid_o, output key_ready_i);

endinterface

// File: rtl/lw_hmac_key_feeder.sv
// Key staging buffer: 16 words written by the host, streamed as one zero-padded key block.
// Latency: first word valid the cycle after a start; 1 word/cycle; done pulse after word 16.
// Backpressure: key_o/key_valid_o hold while key_ready_i is low; abort_i cancels the stream.
// Ports: clk_i/aresetn_i; host side wr_en_i/wr_idx_i/wr_data_i, key_len_i+commit_i, clear_i;
// control stream_start_i/abort_i; key_if (master) to the core; status key_loaded_o, busy_o,
// stream_done_o, err_o.
module lw_hmac_key_feeder
  import lw_sha_pkg::*;
#(
  parameter int KEY_WORDS = KEY_BLOCK_WORDS
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 wr_en_i,
  input  logic [3:0]           wr_idx_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  input  logic [4:0]           key_len_i,
  input  logic                 commit_i,
  input  logic                 clear_i,
  input  logic                 stream_start_i,
  input  logic                 abort_i,
  lw_hmac_key_feeder_if.master key_if,
  output logic                 key_loaded_o,
  output logic                 busy_o,
  output logic                 stream_done_o,
  output logic                 err_o
);

  localparam int IDX_W = $clog2(KEY_WORDS);

  feed_state_e          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4:0]           len_q, len_d;
  logic [WORD_SIZE-1:0] key_q, key_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 buf_we, buf_zero;
  logic                 len_ok;

  // Flop array (not RAM) so clear_i can zeroize every word in one cycle.
  logic [WORD_SIZE-1:0] buf_q [KEY_WORDS];

  // Words at or past the committed length are presented as zero padding.
  function automatic logic [WORD_SIZE-1:0] word_at(input logic [IDX_W-1:0] i);
    return ({1'b0, i} < len_q) ? buf_q[i] : '0;
  endfunction

  assign len_ok = (key_len_i != 5'd0) && (key_len_i <= 5'(KEY_WORDS));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    key_d    = key_q;
    err_d    = err_q;
    done_d   = 1'b0;
    buf_we   = 1'b0;
    buf_zero = 1'b0;

    if (clear_i) begin
      // Zeroize overrides any write, commit, start or transfer in the same cycle.
      buf_zero = 1'b1;
      len_d    = '0;
      key_d    = '0;
      idx_d    = '0;
      err_d    = 1'b0;
      state_d  = FEED_EMPTY;
    end else begin
      case (state_q)
        FEED_EMPTY, FEED_LOADED: begin
          if (wr_en_i) begin
            // A modified key must be re-committed before it can be streamed.
            buf_we  = 1'b1;
            state_d = FEED_EMPTY;
          end
          if (commit_i) begin
            // Evaluated after a same-cycle write, so write+commit ends LOADED.
            if (len_ok) begin
              len_d   = key_len_i;
              err_d   = 1'b0;
              state_d = FEED_LOADED;
            end else begin
              err_d   = 1'b1;
              state_d = FEED_EMPTY;
            end
          end else if (stream_start_i) begin
            if (state_q == FEED_LOADED && !wr_en_i) begin
              idx_d   = '0;
              key_d   = word_at('0);
              state_d = FEED_STREAM;
            end else if (state_q == FEED_EMPTY) begin
              err_d = 1'b1;
            end
          end
        end

        FEED_STREAM: begin
          if (wr_en_i) err_d = 1'b1;
          if (abort_i) begin
            key_d   = '0;
            idx_d   = '0;
            state_d = FEED_LOADED;
          end else if (key_if.key_ready_i) begin
            if (idx_q == IDX_W'(KEY_WORDS - 1)) begin
              key_d   = '0;
              idx_d   = '0;
              done_d  = 1'b1;
              state_d = FEED_LOADED;
            end else begin
              idx_d = idx_q + 1'b1;
              key_d = word_at(idx_q + 1'b1);
            end
          end
        end

        default: state_d = FEED_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= FEED_EMPTY;
      idx_q   <= '0;
      len_q   <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      key_q   <= key_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < KEY_WORDS; i++) buf_q[i] <= '0;
    end else if (buf_zero) begin
      for (int i = 0; i < KEY_WORDS; i++) buf_q[i] <= '0;
    end else if (buf_we) begin
      buf_q[wr_idx_i[IDX_W-1:0]] <= wr_data_i;
    end
  end

  assign key_if.key_o       = key_q;
  assign key_if.key_valid_o = (state_q == FEED_STREAM);
  assign busy_o             = (state_q == FEED_STREAM);
  assign key_loaded_o       = (state_q != FEED_EMPTY);
  assign stream_done_o      = done_q;
  assign err_o              = err_q;

endmodule

// File: doc/lw_hmac_key_feeder.md
Name: lw_hmac_key_feeder

Overview:
- Key staging buffer directly upstream of the HMAC core's key port.
- Software or the host bus writes the HMAC key word by word into a 16-entry buffer.
- Per HMAC operation, the block streams one full key block (16 words, zero-padded past the key length) on a valid/ready handshake into the core's key_i/key_valid_i, in response to its key_ready_o.
- The key persists across operations until explicitly zeroized.

Parameters:
- KEY_WORDS, 16, block size in words; fixed to one hash block; index width $clog2(KEY_WORDS).
- WORD_SIZE, `WORD_SIZE (32 in S32 build, 64 in S64 build), key word width; taken from defines.v, not overridden.

Ports:
- clk_i  in  1  single clock.
- aresetn_i  in  1  asynchronous active-low reset.
- wr_en_i  in  1  key word write strobe.
- wr_idx_i  in  4  word index, 0 = first word in message order.
- wr_data_i  in  WORD_SIZE  key word.
- key_len_i  in  5  key length in words, 1..16, sampled with commit_i.
- commit_i  in  1  marks key complete; latches key_len_i.
- clear_i  in  1  zeroize buffer and length.
- stream_start_i  in  1  begin presenting one key block.
- abort_i  in  1  cancel stream, shared with the HMAC core abort.
- key_ready_i  in  1  from core key_ready_o.
- key_o  out  WORD_SIZE  to core key_i.
- key_valid_o  out  1  to core key_valid_i.
- key_loaded_o  out  1  committed key present.
- busy_o  out  1  streaming in progress.
- stream_done_o  out  1  one-cycle pulse after the 16th transfer.
- err_o  out  1  sticky error; cleared by clear_i or commit_i.

Behaviour:
- Reset: all buffer words 0, length 0, state EMPTY, and every output 0.
- Reset is asynchronous and takes effect immediately mid-stream; key_valid_o drops in the same cycle.
- States: EMPTY, LOADED, STREAM. Encoding is a 2-bit enum.
- Writes:
  - Accepted in EMPTY and LOADED; buf[wr_idx_i] <= wr_data_i next edge.
  - A write in LOADED returns the state to EMPTY (key must be re-committed).
  - A write in STREAM is ignored and sets err_o.
- commit_i:
  - Accepted in EMPTY and LOADED.
  - key_len_i of 0 or >16 sets err_o and leaves the state at EMPTY.
  - Otherwise the length is latched, state goes to LOADED, and key_loaded_o=1 next cycle.
- stream_start_i:
  - In LOADED: index <= 0, state STREAM, key_valid_o=1 from the next cycle.
  - In EMPTY: sets err_o, no stream.
  - In STREAM: ignored.
- STREAM:
  - key_o = (index < len) ? buf[index] : 0. Registered output, stable while key_valid_o && !key_ready_i.
  - Transfer occurs when key_valid_o && key_ready_i at a clock edge; index increments.
  - On the transfer with index==15: key_valid_o deasserts next cycle, stream_done_o pulses for that cycle, state goes to LOADED.
  - Exactly 16 transfers per stream; the index never wraps.
  - Throughput is 1 word/cycle with key_ready_i held high, so 16 cycles from first valid to last transfer.
- abort_i:
  - In STREAM: state goes to LOADED, key_valid_o=0 next cycle, no stream_done_o. Key retained.
  - In other states: no effect.
- clear_i has the highest priority over every simultaneous event, including a write, commit, start, or a transfer on the same cycle.
  - All buffer words and the length go to 0, key_o goes to 0, state goes to EMPTY, err_o goes to 0, next edge.
- Simultaneous abort_i and the final transfer: abort wins; no stream_done_o.
- Simultaneous commit_i and wr_en_i in LOADED: the write lands, then the commit is evaluated, so the result is LOADED with the new data.
- busy_o = (state==STREAM). key_loaded_o = (state != EMPTY).

Decomposition:
- Shared package lw_sha_pkg gains:
  - feeder state enum type;
  - constant KEY_BLOCK_WORDS=16;
  - ipad/opad byte constants 8'h36/8'h5c, for the core's later use.
- No sub-module: the buffer is a register array inside the block, because zeroization requires a flop array, not RAM.

Test Plan:
- S32 build: write words 0..3 = 32'h0B0B0B0B, commit len=4, start, key_ready_i=1 -> 16 transfers: 4×0B0B0B0B then 12×0; stream_done_o high one cycle after the 16th; key_loaded_o stays 1.
- Backpressure: toggle key_ready_i 1,0,0,1,... -> key_o/key_valid_o stable while not ready; sequence unchanged; still exactly 16 transfers.
- Abort after 5 transfers -> key_valid_o=0 next cycle, no done pulse; restart streams from word 0 again with the same key.
- clear_i on the same cycle as the 10th transfer -> next cycle state EMPTY, key_valid_o=0, all buffer words read 0; a subsequent start sets err_o.
- Commit len=0 and len=17 -> err_o=1, key_loaded_o=0; then commit len=16 -> err_o=0, key_loaded_o=1.
- Write during STREAM -> err_o=1, streamed data unchanged; aresetn_i low mid-stream -> all outputs 0 immediately, buffer zero.
